// File: rtl/collatz_sweep_if.sv
// Control/status bundle for collatz_sweep: sweep launch, result RAM read port and sweep statistics.
interface collatz_sweep_if #(
    parameter int N_BITS    = 32,
    parameter int CNT_BITS  = 16,
    parameter int ADDR_BITS = 4
);
    logic                 go;
    logic [N_BITS-1:0]    start;
    logic [ADDR_BITS-1:0] len;
    logic [ADDR_BITS-1:0] rd_addr;
    logic [CNT_BITS-1:0]  count;
    logic                 busy;
    logic                 done;
    logic [CNT_BITS-1:0]  max_count;
    logic [ADDR_BITS-1:0] max_addr;
    logic                 ovf;

    modport master (
        output go, start, len, rd_addr,
        input  count, busy, done, max_count, max_addr, ovf
    );

    modport slave (
        input  go, start, len, rd_addr,
        output count, busy, done, max_count, max_addr, ovf
    );
endinterface

// File: rtl/collatz_sweep.sv
// Sweeps Collatz sequence lengths over start..start+len-1 into a small result RAM,
// tracking the largest count and an overflow/saturation flag.
module collatz_sweep #(
    parameter int N_BITS    = 32,
    parameter int CNT_BITS  = 16,
    parameter int RAM_WORDS = 16,
    parameter int ADDR_BITS = 4
) (
    input  logic              clk,
    input  logic              reset,
    collatz_sweep_if.slave    bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ITER  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};

    state_t               state_q;
    logic [N_BITS-1:0]    start_q;
    logic [ADDR_BITS-1:0] len_q;
    logic [ADDR_BITS-1:0] num_q;
    logic [N_BITS-1:0]    n_q;
    logic [CNT_BITS-1:0]  cnt_q;
    logic [CNT_BITS-1:0]  max_count_q;
    logic [ADDR_BITS-1:0] max_addr_q;
    logic                 ovf_q;
    logic                 busy_q;
    logic                 done_q;
    logic [CNT_BITS-1:0]  count_q;
    logic [CNT_BITS-1:0]  mem_q [RAM_WORDS];

    logic [N_BITS+1:0]    triple_s;
    logic                 triple_ovf_s;
    logic [N_BITS-1:0]    n_d;
    logic [CNT_BITS-1:0]  cnt_d;
    logic                 cnt_sat_s;
    logic [N_BITS-1:0]    load_n_s;
    logic [ADDR_BITS-1:0] last_num_s;

    // One Collatz step on n_q, widened by two bits so a 3n+1 overflow is visible.
    always_comb begin
        triple_s     = ({2'b00, n_q} << 1) + {2'b00, n_q} + (N_BITS+2)'(1);
        triple_ovf_s = |triple_s[N_BITS+1:N_BITS];
        if (n_q[0]) begin
            n_d = triple_s[N_BITS-1:0];
        end else begin
            n_d = n_q >> 1;
        end
        cnt_sat_s  = (cnt_q == CNT_MAX);
        cnt_d      = cnt_sat_s ? cnt_q : (cnt_q + CNT_BITS'(1));
        load_n_s   = start_q + N_BITS'(num_q);
        // len of 0 wraps to all-ones, i.e. the last RAM address.
        last_num_s = len_q - ADDR_BITS'(1);
    end

    // Sweep controller with registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            start_q     <= {N_BITS{1'b0}};
            len_q       <= {ADDR_BITS{1'b0}};
            num_q       <= {ADDR_BITS{1'b0}};
            n_q         <= {N_BITS{1'b0}};
            cnt_q       <= {CNT_BITS{1'b0}};
            max_count_q <= {CNT_BITS{1'b0}};
            max_addr_q  <= {ADDR_BITS{1'b0}};
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.go) begin
                        start_q     <= bus.start;
                        len_q       <= bus.len;
                        num_q       <= {ADDR_BITS{1'b0}};
                        max_count_q <= {CNT_BITS{1'b0}};
                        max_addr_q  <= {ADDR_BITS{1'b0}};
                        ovf_q       <= 1'b0;
                        done_q      <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // 0 and 1 need no iteration, so a count of 1 costs only LOAD+WRITE.
                    n_q <= load_n_s;
                    if (load_n_s == N_BITS'(0)) begin
                        cnt_q   <= CNT_BITS'(0);
                        state_q <= S_WRITE;
                    end else if (load_n_s == N_BITS'(1)) begin
                        cnt_q   <= CNT_BITS'(1);
                        state_q <= S_WRITE;
                    end else begin
                        cnt_q   <= CNT_BITS'(1);
                        state_q <= S_ITER;
                    end
                end
                S_ITER: begin
                    if (n_q[0] && triple_ovf_s) begin
                        ovf_q   <= 1'b1;
                        state_q <= S_WRITE;
                    end else begin
                        n_q   <= n_d;
                        cnt_q <= cnt_d;
                        if (cnt_sat_s) begin
                            ovf_q <= 1'b1;
                        end
                        if (n_d <= N_BITS'(1)) begin
                            state_q <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (cnt_q > max_count_q) begin
                        max_count_q <= cnt_q;
                        max_addr_q  <= num_q;
                    end
                    if (num_q == last_num_s) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        num_q   <= num_q + ADDR_BITS'(1);
                        state_q <= S_LOAD;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Result RAM: write in WRITE unless reset; read port returns pre-write data.
    always_ff @(posedge clk) begin
        if (!reset && (state_q == S_WRITE)) begin
            mem_q[num_q] <= cnt_q;
        end
        count_q <= mem_q[bus.rd_addr];
    end

    assign bus.count     = count_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.max_count = max_count_q;
    assign bus.max_addr  = max_addr_q;
    assign bus.ovf       = ovf_q;
endmodule
